// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions a raw, bouncy, asynchronous input (push-button or switch) for the
// 3-state control FSM. The input passes through a flop synchronizer into the
// CLK domain. A four-state debounce machine then filters it and presents a
// clean level with one-cycle rise/fall strobes. The downstream FSM sees exactly
// one transition per physical press or release.
//
// Parameters
//   SYNC_STAGES      synchronizer flop count (>= 2)
//   DEBOUNCE_CYCLES  qualifying TICKs required before In_clean changes (>= 1)
//   GLITCH_W         glitch counter width (used only with the optional counter)
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   In_raw     in   raw asynchronous input
//   TICK       in   debounce sample strobe (tie to 1 to count every clock)
//   In_clean   out  debounced level (drives FSM In1)
//   Rise       out  one-cycle pulse when In_clean goes 0->1
//   Fall       out  one-cycle pulse when In_clean goes 1->0
//   Busy       out  high while a candidate transition is being qualified
//
// Optional feature, enabled by defining IN_DEBOUNCE_GLITCH_CNT_EN:
//   Glitch_clr in   synchronous clear of the glitch counter (wins over increment)
//   Glitch_cnt out  saturating count of aborted qualifications
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_W        = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                In_raw,
    input  logic                TICK,
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    input  logic                Glitch_clr,
    output logic [GLITCH_W-1:0] Glitch_cnt,
`endif
    output logic                In_clean,
    output logic                Rise,
    output logic                Fall,
    output logic                Busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal configurations at elaboration time.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || GLITCH_W < 1) begin : g_bad_params
        $error("input_debouncer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_LO = 2'd0,
        P_HI = 2'd1,
        S_HI = 2'd2,
        P_LO = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync;
    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;

    // Plain flop chain: nothing combinational between stages, so metastability
    // has a full clock period to resolve at every stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], In_raw};
        end
    end

    assign sync = sync_reg[SYNC_STAGES-1];

    // Debounce machine. In a pending state the abort test comes first, so an
    // input that drops back on the very cycle the count would qualify is still
    // treated as a glitch. The counter is cleared on entry and only moves on
    // TICK; it stops at CNT_LAST because that value qualifies and leaves the
    // pending state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_LO;
            cnt_reg   <= '0;
            In_clean  <= 1'b0;
            Rise      <= 1'b0;
            Fall      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            Rise <= 1'b0;
            Fall <= 1'b0;
            case (state_reg)
                S_LO: begin
                    if (sync) begin
                        state_reg <= P_HI;
                        cnt_reg   <= '0;
                        Busy      <= 1'b1;
                    end
                end
                P_HI: begin
                    if (!sync) begin
                        state_reg <= S_LO;
                        Busy      <= 1'b0;
                    end else if (TICK) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= S_HI;
                            In_clean  <= 1'b1;
                            Rise      <= 1'b1;
                            Busy      <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (!sync) begin
                        state_reg <= P_LO;
                        cnt_reg   <= '0;
                        Busy      <= 1'b1;
                    end
                end
                P_LO: begin
                    if (sync) begin
                        state_reg <= S_HI;
                        Busy      <= 1'b0;
                    end else if (TICK) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= S_LO;
                            In_clean  <= 1'b0;
                            Fall      <= 1'b1;
                            Busy      <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_LO;
                    cnt_reg   <= '0;
                    In_clean  <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    // An abort is a pending state whose synchronized input went back.
    logic abort;

    assign abort = ((state_reg == P_HI) && !sync) || ((state_reg == P_LO) && sync);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Glitch_cnt <= '0;
        end else if (Glitch_clr) begin
            Glitch_cnt <= '0;
        end else if (abort && (Glitch_cnt != {GLITCH_W{1'b1}})) begin
            Glitch_cnt <= Glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Self-checking bench for input_debouncer with default parameters. Stimulus
// is a table of segments. Each segment holds In_raw/TICK for a number of
// clocks and gives the outputs expected at its end. The expectation is queued
// when the segment is driven and popped for comparison once its clocks have
// elapsed. Hand-written sequences then cover asynchronous reset and, when
// IN_DEBOUNCE_GLITCH_CNT_EN is defined, the glitch counter.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int GLITCH_W = 8;

    logic CLK = 1'b0;
    logic RST;
    logic In_raw;
    logic TICK;
    logic In_clean;
    logic Rise;
    logic Fall;
    logic Busy;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    logic                Glitch_clr;
    logic [GLITCH_W-1:0] Glitch_cnt;
`endif

    int total  = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .GLITCH_W       (GLITCH_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_raw    (In_raw),
        .TICK      (TICK),
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
        .Glitch_clr(Glitch_clr),
        .Glitch_cnt(Glitch_cnt),
`endif
        .In_clean  (In_clean),
        .Rise      (Rise),
        .Fall      (Fall),
        .Busy      (Busy)
    );

    // tick_per: 0 = TICK held low, N = TICK on cycle 0, N, 2N ... of the segment
    typedef struct {
        string name;
        logic  raw;
        int    tick_per;
        int    cycles;
        logic  clean;
        logic  rise;
        logic  fall;
        logic  busy;
        int    glitch;
    } seg_t;

    seg_t segs[$];
    seg_t exp_q[$];

    function automatic seg_t mk(input string n, input logic r, input int p, input int c,
                                input logic cl, input logic ri, input logic fa,
                                input logic bu, input int g);
        seg_t s;
        s.name = n; s.raw = r; s.tick_per = p; s.cycles = c;
        s.clean = cl; s.rise = ri; s.fall = fa; s.busy = bu; s.glitch = g;
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_seg(input seg_t s);
        seg_t e;
        int   early_strobe = 0;
        int   both_strobe  = 0;
        exp_q.push_back(s);
        for (int k = 0; k < s.cycles; k++) begin
            In_raw = s.raw;
            TICK   = (s.tick_per == 0) ? 1'b0 : ((k % s.tick_per) == 0);
            @(posedge CLK);
            #1;
            if ((k < s.cycles - 1) && (Rise || Fall)) early_strobe++;
            if (Rise && Fall) both_strobe++;
        end
        e = exp_q.pop_front();
        $display("seg %-14s raw=%0b cyc=%0d : clean=%0b rise=%0b fall=%0b busy=%0b",
                 e.name, e.raw, e.cycles, In_clean, Rise, Fall, Busy);
        chk({e.name, ".clean"}, In_clean, e.clean);
        chk({e.name, ".rise"},  Rise,     e.rise);
        chk({e.name, ".fall"},  Fall,     e.fall);
        chk({e.name, ".busy"},  Busy,     e.busy);
        chk({e.name, ".quiet"}, early_strobe, 0);
        chk({e.name, ".excl"},  both_strobe,  0);
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
        chk({e.name, ".glitch"}, int'(Glitch_cnt), e.glitch);
`endif
    endtask

    task automatic tick_raw(input logic r, input int n);
        for (int k = 0; k < n; k++) begin
            In_raw = r;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST    = 1'b1;
        In_raw = 1'b0;
        TICK   = 1'b1;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
        Glitch_clr = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        chk("reset.clean", In_clean, 0);
        chk("reset.rise",  Rise, 0);
        chk("reset.fall",  Fall, 0);
        chk("reset.busy",  Busy, 0);
        RST = 1'b0;

        //                 name            raw per cyc  cl ri fa bu  g
        segs.push_back(mk("press_sync",    1, 1,  2,  0, 0, 0, 0, 0));
        segs.push_back(mk("press_busy",    1, 1,  1,  0, 0, 0, 1, 0));
        segs.push_back(mk("press_count",   1, 1, 15,  0, 0, 0, 1, 0));
        segs.push_back(mk("press_rise",    1, 1,  1,  1, 1, 0, 0, 0));
        segs.push_back(mk("press_after",   1, 1,  1,  1, 0, 0, 0, 0));
        segs.push_back(mk("press_hold",    1, 1, 10,  1, 0, 0, 0, 0));
        segs.push_back(mk("rel_sync",      0, 1,  2,  1, 0, 0, 0, 0));
        segs.push_back(mk("rel_busy",      0, 1,  1,  1, 0, 0, 1, 0));
        segs.push_back(mk("rel_count",     0, 1, 15,  1, 0, 0, 1, 0));
        segs.push_back(mk("rel_fall",      0, 1,  1,  0, 0, 1, 0, 0));
        segs.push_back(mk("rel_after",     0, 1,  5,  0, 0, 0, 0, 0));
        segs.push_back(mk("bnc5_hi",       1, 1,  5,  0, 0, 0, 1, 0));
        segs.push_back(mk("bnc5_tail",     0, 1,  2,  0, 0, 0, 1, 0));
        segs.push_back(mk("bnc5_abort",    0, 1,  1,  0, 0, 0, 0, 1));
        segs.push_back(mk("bnc5_idle",     0, 1, 20,  0, 0, 0, 0, 1));
        // Abort lands on the cycle where the count would qualify.
        segs.push_back(mk("bnc16_hi",      1, 1, 16,  0, 0, 0, 1, 1));
        segs.push_back(mk("bnc16_tail",    0, 1,  2,  0, 0, 0, 1, 1));
        segs.push_back(mk("bnc16_abort",   0, 1,  1,  0, 0, 0, 0, 2));
        segs.push_back(mk("bnc16_idle",    0, 1,  5,  0, 0, 0, 0, 2));
        segs.push_back(mk("slow_enter",    1, 4,  3,  0, 0, 0, 1, 2));
        segs.push_back(mk("slow_15tick",   1, 4, 60,  0, 0, 0, 1, 2));
        segs.push_back(mk("slow_notick",   1, 0, 20,  0, 0, 0, 1, 2));
        segs.push_back(mk("slow_rise",     1, 1,  1,  1, 1, 0, 0, 2));
        segs.push_back(mk("slow_after",    1, 1,  1,  1, 0, 0, 0, 2));
        segs.push_back(mk("rel2_sync",     0, 1,  2,  1, 0, 0, 0, 2));
        segs.push_back(mk("rel2_count",    0, 1, 16,  1, 0, 0, 1, 2));
        segs.push_back(mk("rel2_fall",     0, 1,  1,  0, 0, 1, 0, 2));
        segs.push_back(mk("rel2_idle",     0, 1,  3,  0, 0, 0, 0, 2));
        segs.push_back(mk("mid_press",     1, 1,  3,  0, 0, 0, 1, 2));
        segs.push_back(mk("mid_cnt10",     1, 1, 10,  0, 0, 0, 1, 2));

        foreach (segs[i]) run_seg(segs[i]);

        // Asynchronous reset mid-qualification: outputs clear between edges.
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mid.busy",  Busy, 0);
        chk("rst_mid.clean", In_clean, 0);
        @(posedge CLK);
        #1;
        chk("rst_hold.busy", Busy, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        $display("rst_mid: reset applied and released with In_raw=1");

        // Full latency restarts from the first edge after release.
        run_seg(mk("rst_restart",  1, 1, 18, 0, 0, 0, 1, 0));
        run_seg(mk("rst_rise",     1, 1,  1, 1, 1, 0, 0, 0));
        run_seg(mk("rst_hi_hold",  1, 1,  5, 1, 0, 0, 0, 0));

        // Reset while in the stable-high state.
        #2;
        RST = 1'b1;
        #1;
        chk("rst_shi.clean", In_clean, 0);
        chk("rst_shi.rise",  Rise, 0);
        In_raw = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        $display("rst_shi: reset from stable-high, clean=%0b", In_clean);
        run_seg(mk("post_rst_idle", 0, 1, 4, 0, 0, 0, 0, 0));

`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
        // 260 short bounces: counter must saturate at all-ones.
        for (int g = 0; g < 260; g++) begin
            tick_raw(1'b1, 3);
            tick_raw(1'b0, 3);
        end
        $display("glitch_sat: Glitch_cnt=%0d", Glitch_cnt);
        chk("glitch_sat", int'(Glitch_cnt), 255);
        tick_raw(1'b1, 3);
        tick_raw(1'b0, 3);
        $display("glitch_sat_abort: Glitch_cnt=%0d", Glitch_cnt);
        chk("glitch_sat_abort", int'(Glitch_cnt), 255);
        // Clear coinciding with an abort: clear wins.
        tick_raw(1'b1, 3);
        tick_raw(1'b0, 2);
        Glitch_clr = 1'b1;
        tick_raw(1'b0, 1);
        Glitch_clr = 1'b0;
        $display("glitch_clr_abort: Glitch_cnt=%0d busy=%0b", Glitch_cnt, Busy);
        chk("glitch_clr_abort", int'(Glitch_cnt), 0);
        chk("glitch_clr_busy",  Busy, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
